// File: rtl/rv_pipe_pkg.sv
// Shared encodings for the RV32I pipeline hazard controller: forward selects,
// controller states, the zero register and the default trap vector.
package rv_pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_MWAIT = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;

  localparam logic [4:0]  ZERO_REG         = 5'd0;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  // x0 is hardwired, so a write to it never creates a dependency.
  function automatic logic raw_hit(input logic en, input logic [4:0] rs,
                                   input logic [4:0] rd, input logic wen);
    return en & wen & (rd != ZERO_REG) & (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Per-operand RAW compare: forward select and stall request for one ID source.
module pipe_fwd_unit
  import rv_pipe_pkg::*;
(
  input  logic       fwd_en,
  input  logic       rs_en,
  input  logic [4:0] rs_addr,
  input  logic [4:0] ex_rd,
  input  logic       ex_wen,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_wen,
  input  logic [4:0] wb_rd,
  input  logic       wb_wen,
  output logic [1:0] fwd_sel,
  output logic       stall_hit
);

  logic ex_hit, mem_hit, wb_hit;

  always_comb begin
    ex_hit  = raw_hit(rs_en, rs_addr, ex_rd, ex_wen);
    mem_hit = raw_hit(rs_en, rs_addr, mem_rd, mem_wen);
    wb_hit  = raw_hit(rs_en, rs_addr, wb_rd, wb_wen);
    fwd_sel = FWD_REG;
    if (fwd_en) begin
      if (mem_hit)     fwd_sel = FWD_MEM;
      else if (wb_hit) fwd_sel = FWD_WB;
    end
    // Without bypass paths, any in-flight producer must drain before ID issues.
    stall_hit = fwd_en ? (ex_hit & ex_is_load) : (ex_hit | mem_hit | wb_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline.
// Define PIPE_FWD_EN to enable operand forwarding; otherwise RAW hazards stall.
module pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC    = TRAP_VEC_DEFAULT,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_rs1en,
  input  logic             id_rs2en,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_illegal,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_rd_wen,
  input  logic             mem_rd_wen,
  input  logic             wb_rd_wen,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      trap_pc,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

`ifdef PIPE_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       a_stall, b_stall, hazard, freeze, illegal_go;

  pipe_fwd_unit u_fwd_a (
    .fwd_en(FWD_ON), .rs_en(id_rs1en), .rs_addr(id_rs1_addr),
    .ex_rd(ex_rd), .ex_wen(ex_rd_wen), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_wen(mem_rd_wen), .wb_rd(wb_rd), .wb_wen(wb_rd_wen),
    .fwd_sel(fwd_a_sel), .stall_hit(a_stall)
  );

  pipe_fwd_unit u_fwd_b (
    .fwd_en(FWD_ON), .rs_en(id_rs2en), .rs_addr(id_rs2_addr),
    .ex_rd(ex_rd), .ex_wen(ex_rd_wen), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_wen(mem_rd_wen), .wb_rd(wb_rd), .wb_wen(wb_rd_wen),
    .fwd_sel(fwd_b_sel), .stall_hit(b_stall)
  );

  always_comb begin
    hazard     = a_stall | b_stall;
    freeze     = (mem_req & ~mem_ready) | ((state == ST_MWAIT) & ~mem_ready);
    illegal_go = id_illegal & ~freeze & ~hazard & ~ex_br_taken;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = ex_br_target;
    if (state == ST_TRAP) begin
      redirect    = 1'b1;
      redirect_pc = TRAP_VEC;
      flush_id    = 1'b1;
      flush_ex    = 1'b1;
    end else if (freeze) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (ex_br_taken) begin
      redirect = 1'b1;
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (hazard) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      trap_pc   <= '0;
      stall_cnt <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (stall_if) stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        ST_RUN: begin
          if (mem_req & ~mem_ready) begin
            state    <= ST_MWAIT;
            wait_cnt <= 8'd1;
          end else if (illegal_go) begin
            state   <= ST_TRAP;
            trap_pc <= id_pc;
          end
        end
        ST_MWAIT: begin
          if (mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ST_TRAP;
            wait_cnt <= '0;
            bus_err  <= 1'b1;
            trap_pc  <= id_pc;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the controller.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_rs1en, id_rs2en, id_illegal;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd, mem_rd, wb_rd;
  logic [31:0] id_pc, ex_br_target;
  logic        ex_rd_wen, mem_rd_wen, wb_rd_wen, ex_is_load, ex_br_taken;
  logic        mem_req, mem_ready;
  logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        redirect, bus_err;
  logic [31:0] redirect_pc, trap_pc, stall_cnt;

  int checks = 0;
  int failures = 0;

  // Model state: waiting on memory, how many cycles waited, trap pending.
  bit          m_wait, m_trap, m_buserr;
  int          m_waited;
  logic [31:0] m_trap_pc, m_cnt;
  bit          e_stall_if, e_hazard;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TRAP_VEC(32'h0000_0100), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1en(id_rs1en), .id_rs2en(id_rs2en),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_illegal(id_illegal), .id_pc(id_pc),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rd_wen(ex_rd_wen), .mem_rd_wen(mem_rd_wen), .wb_rd_wen(wb_rd_wen),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .redirect(redirect), .redirect_pc(redirect_pc), .trap_pc(trap_pc),
    .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dep(input bit en, input logic [4:0] rs, input logic [4:0] rd, input bit wen);
    return en && wen && rd != 5'd0 && rs == rd;
  endfunction

  function automatic logic [1:0] fsel(input bit en, input logic [4:0] rs);
`ifdef PIPE_FWD_EN
    if (dep(en, rs, mem_rd, mem_rd_wen)) return 2'b01;
    if (dep(en, rs, wb_rd, wb_rd_wen)) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic bit needs_stall(input bit en, input logic [4:0] rs);
`ifdef PIPE_FWD_EN
    return ex_is_load && dep(en, rs, ex_rd, ex_rd_wen);
`else
    return dep(en, rs, ex_rd, ex_rd_wen) || dep(en, rs, mem_rd, mem_rd_wen) ||
           dep(en, rs, wb_rd, wb_rd_wen);
`endif
  endfunction

  task automatic idle();
    id_rs1en = 0; id_rs2en = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    id_illegal = 0; id_pc = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_rd_wen = 0; mem_rd_wen = 0; wb_rd_wen = 0; ex_is_load = 0;
    ex_br_taken = 0; ex_br_target = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_trap = 0; m_buserr = 0; m_waited = 0; m_trap_pc = 0; m_cnt = 0;
  endtask

  // Check one cycle at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit frz, s_all, s_fe, f_id, f_ex, rdr;
    logic [31:0] rpc;
    #4;
    e_hazard = needs_stall(id_rs1en, id_rs1_addr) || needs_stall(id_rs2en, id_rs2_addr);
    frz = (mem_req && !mem_ready) || (m_wait && !mem_ready);
    s_all = 0; s_fe = 0; f_id = 0; f_ex = 0; rdr = 0; rpc = ex_br_target;
    if (m_trap) begin
      rdr = 1; rpc = 32'h100; f_id = 1; f_ex = 1;
    end else if (frz) begin
      s_all = 1; s_fe = 1;
    end else if (ex_br_taken) begin
      rdr = 1; f_id = 1; f_ex = 1;
    end else if (e_hazard) begin
      s_fe = 1; f_ex = 1;
    end
    e_stall_if = s_fe;
    chk("stall_if", 32'(stall_if), 32'(s_fe));
    chk("stall_id", 32'(stall_id), 32'(s_fe));
    chk("stall_ex", 32'(stall_ex), 32'(s_all));
    chk("stall_mem", 32'(stall_mem), 32'(s_all));
    chk("flush_id", 32'(flush_id), 32'(f_id));
    chk("flush_ex", 32'(flush_ex), 32'(f_ex));
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(fsel(id_rs1en, id_rs1_addr)));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(fsel(id_rs2en, id_rs2_addr)));
    chk("redirect", 32'(redirect), 32'(rdr));
    if (rdr) chk("redirect_pc", redirect_pc, rpc);
    chk("trap_pc", trap_pc, m_trap_pc);
    chk("bus_err", 32'(bus_err), 32'(m_buserr));
    chk("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    if (e_stall_if) m_cnt = m_cnt + 1;
    m_buserr = 0;
    if (m_trap) m_trap = 0;
    else if (m_wait) begin
      if (mem_ready) m_wait = 0;
      else if (m_waited == 15) begin
        m_wait = 0; m_trap = 1; m_buserr = 1; m_trap_pc = id_pc;
      end else m_waited++;
    end else if (mem_req && !mem_ready) begin
      m_wait = 1; m_waited = 1;
    end else if (id_illegal && !e_hazard && !ex_br_taken) begin
      m_trap = 1; m_trap_pc = id_pc;
    end
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    #12;
    chk("reset_redirect", 32'(redirect), 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    cycle();

    // add x3,x1,x2 with producers in MEM (x1) and WB (x2)
    id_rs1en = 1; id_rs2en = 1; id_rs1_addr = 1; id_rs2_addr = 2;
    mem_rd = 1; mem_rd_wen = 1; wb_rd = 2; wb_rd_wen = 1;
    cycle();
    idle();

    // load-use on x5, then the same pattern with rd=x0
    ex_is_load = 1; ex_rd = 5; ex_rd_wen = 1; id_rs1en = 1; id_rs1_addr = 5;
    cycle();
    ex_rd = 0; id_rs1_addr = 0;
    cycle();
    idle();

    // taken branch overriding a simultaneous load-use
    ex_is_load = 1; ex_rd = 5; ex_rd_wen = 1; id_rs1en = 1; id_rs1_addr = 5;
    ex_br_taken = 1; ex_br_target = 32'h80;
    cycle();
    idle();

    // memory stall of three cycles
    mem_req = 1; mem_ready = 0;
    repeat (3) cycle();
    mem_ready = 1;
    cycle();
    idle();
    cycle();

    // memory never ready: bus timeout trap
    mem_req = 1; mem_ready = 0; id_pc = 32'h0000_0abc;
    repeat (16) cycle();
    mem_req = 0;
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    cycle();
    idle();
    cycle();

    // illegal instruction trap, then one with reset asserted during TRAP
    id_illegal = 1; id_pc = 32'h44;
    cycle();
    idle();
    chk("illegal_trap_pc", trap_pc, 32'h44);
    cycle();
    id_illegal = 1; id_pc = 32'h48;
    cycle();
    idle();
    rst_n = 0;
    model_reset();
    #2;
    chk("reset_in_trap_redirect", 32'(redirect), 32'd0);
    chk("reset_in_trap_pc", trap_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      id_rs1en = 1'($urandom); id_rs2en = 1'($urandom);
      id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      ex_rd_wen = 1'($urandom); mem_rd_wen = 1'($urandom); wb_rd_wen = 1'($urandom);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      ex_br_target = {$urandom, 2'b00} & 32'hffff_fffc;
      id_illegal = ($urandom_range(0, 15) == 0);
      id_pc = $urandom & 32'hffff_fffc;
      mem_req = ($urandom_range(0, 5) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
